// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor: WIDTH bits resolved SLICE bits per stage,
// 4-bit CLA groups with a second-level lookahead per slice, valid/ready with global stall.
module cla_addsub_pipe #(
    parameter int WIDTH = 32,
    parameter int SLICE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg
);

    localparam int NSTAGE = WIDTH / SLICE;
    localparam int NGRP   = SLICE / 4;
    localparam int FWD_W  = (NSTAGE > 1) ? (NSTAGE * WIDTH - (SLICE * NSTAGE * (NSTAGE - 1)) / 2 - WIDTH) : 1;

    // Offset of rank r's forwarded B operand inside fwd_s; rank r keeps only B[WIDTH-1:SLICE*r].
    function automatic int fwd_off(input int r);
        return r * WIDTH - (SLICE * r * (r - 1)) / 2 - WIDTH;
    endfunction

    // One slice: returns {carry_out, sum}. Group P/G feed a sum-of-products lookahead across groups.
    function automatic logic [SLICE:0] cla_slice(
        input logic [SLICE-1:0] a,
        input logic [SLICE-1:0] b,
        input logic             cin
    );
        logic [SLICE-1:0] p;
        logic [SLICE-1:0] g;
        logic [SLICE-1:0] c;
        logic [NGRP-1:0]  gp;
        logic [NGRP-1:0]  gg;
        logic [NGRP:0]    gc;
        logic             prod;
        logic             term;
        int               base;
        p = a ^ b;
        g = a & b;
        for (int j = 0; j < NGRP; j++) begin
            base  = 4 * j;
            gp[j] = &p[base +: 4];
            gg[j] = g[base+3] | (p[base+3] & g[base+2]) | (p[base+3] & p[base+2] & g[base+1])
                  | (p[base+3] & p[base+2] & p[base+1] & g[base]);
        end
        gc[0] = cin;
        for (int j = 0; j < NGRP; j++) begin
            prod = 1'b1;
            term = 1'b0;
            for (int i = j; i >= 0; i--) begin
                term = term | (gg[i] & prod);
                prod = prod & gp[i];
            end
            gc[j+1] = term | (prod & cin);
        end
        for (int j = 0; j < NGRP; j++) begin
            base      = 4 * j;
            c[base]   = gc[j];
            c[base+1] = g[base] | (p[base] & gc[j]);
            c[base+2] = g[base+1] | (p[base+1] & g[base]) | (p[base+1] & p[base] & gc[j]);
            c[base+3] = g[base+2] | (p[base+2] & g[base+1]) | (p[base+2] & p[base+1] & g[base])
                      | (p[base+2] & p[base+1] & p[base] & gc[j]);
        end
        return {gc[NGRP], p ^ c};
    endfunction

    // Rank 0 is the operand register; rank r holds sums of slices below r and raw A above.
    logic [NSTAGE:0]            v_r;
    logic [NSTAGE:0][WIDTH-1:0] x_r;
    logic [NSTAGE:0]            c_r;
    logic [NSTAGE:1]            z_r;
    logic                       ovf_r;
    logic                       rdy_en_r;

    logic                       stall_s;
    logic                       accept_s;
    logic [WIDTH-1:0]           b_eff_s;
    logic                       c0_s;

    wire  [NSTAGE:1][WIDTH-1:0] x_nxt_s;
    wire  [NSTAGE:1]            c_nxt_s;
    wire  [NSTAGE:1]            z_nxt_s;
    wire  [FWD_W-1:0]           fwd_s;
    wire                        ovf_nxt_s;

    assign stall_s  = v_r[NSTAGE] & ~out_ready;
    assign in_ready = rdy_en_r & ~stall_s;
    assign accept_s = in_valid & in_ready;
    assign b_eff_s  = in_sub ? ~in_b : in_b;
    assign c0_s     = in_sub ? ~in_cin : in_cin;

    assign out_valid = v_r[NSTAGE];
    assign out_s     = x_r[NSTAGE];
    assign out_cout  = c_r[NSTAGE];
    assign out_ovf   = ovf_r;
    assign out_zero  = z_r[NSTAGE];
    assign out_neg   = x_r[NSTAGE][WIDTH-1];

    if (NSTAGE == 1) begin : g_nofwd
        assign fwd_s = 1'b0;
    end

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        localparam int BW = WIDTH - SLICE * k;
        logic [BW-1:0]    b_r;
        logic [SLICE-1:0] a_sl_s;
        logic [SLICE:0]   res_s;
        logic [WIDTH-1:0] x_upd_s;
        logic             z_in_s;

        assign a_sl_s = x_r[k][SLICE*k +: SLICE];
        assign res_s  = cla_slice(a_sl_s, b_r[SLICE-1:0], c_r[k]);

        if (k == 0) begin : g_first
            // Conditioned operand B captured on accept.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    b_r <= {BW{1'b0}};
                end else if (!stall_s && accept_s) begin
                    b_r <= b_eff_s;
                end
            end
            assign z_in_s = 1'b1;
        end else begin : g_next
            localparam int OFF = fwd_off(k);
            // Unconsumed upper B bits handed on from the previous rank.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    b_r <= {BW{1'b0}};
                end else if (!stall_s && v_r[k-1]) begin
                    b_r <= fwd_s[OFF +: BW];
                end
            end
            assign z_in_s = z_r[k];
        end

        if (k < NSTAGE - 1) begin : g_fwd
            assign fwd_s[fwd_off(k+1) +: BW-SLICE] = b_r[BW-1:SLICE];
        end else begin : g_last
            // Carry into the MSB is recovered as sum ^ a ^ b at the top bit.
            assign ovf_nxt_s = res_s[SLICE] ^ (res_s[SLICE-1] ^ a_sl_s[SLICE-1] ^ b_r[SLICE-1]);
        end

        // Splice this slice's sum into the A/sum word.
        always_comb begin
            x_upd_s = x_r[k];
            x_upd_s[SLICE*k +: SLICE] = res_s[SLICE-1:0];
        end

        assign x_nxt_s[k+1] = x_upd_s;
        assign c_nxt_s[k+1] = res_s[SLICE];
        assign z_nxt_s[k+1] = z_in_s & ~(|res_s[SLICE-1:0]);
    end

    // Valid, sum/operand, carry, zero and overflow ranks; the whole pipe freezes on stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_r      <= {(NSTAGE+1){1'b0}};
            x_r      <= {((NSTAGE+1)*WIDTH){1'b0}};
            c_r      <= {(NSTAGE+1){1'b0}};
            z_r      <= {NSTAGE{1'b0}};
            ovf_r    <= 1'b0;
            rdy_en_r <= 1'b0;
        end else begin
            rdy_en_r <= 1'b1;
            if (!stall_s) begin
                v_r[0] <= accept_s;
                if (accept_s) begin
                    x_r[0] <= in_a;
                    c_r[0] <= c0_s;
                end
                for (int r = 1; r <= NSTAGE; r++) begin
                    v_r[r] <= v_r[r-1];
                    if (v_r[r-1]) begin
                        x_r[r] <= x_nxt_s[r];
                        c_r[r] <= c_nxt_s[r];
                        z_r[r] <= z_nxt_s[r];
                    end
                end
                if (v_r[NSTAGE-1]) begin
                    ovf_r <= ovf_nxt_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Self-checking bench for cla_addsub_pipe: directed corner cases plus random traffic
// compared against an arithmetic reference and an ideal fixed-latency pipe.
module tb_cla_addsub_pipe;

    localparam int W  = 32;
    localparam int SL = 16;
    localparam int N  = W / SL;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_s;
    logic         out_cout;
    logic         out_ovf;
    logic         out_zero;
    logic         out_neg;

    always #5 clk = ~clk;

    cla_addsub_pipe #(.WIDTH(W), .SLICE(SL)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_s(out_s), .out_cout(out_cout), .out_ovf(out_ovf),
        .out_zero(out_zero), .out_neg(out_neg)
    );

    typedef struct packed {
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
        logic         zero;
        logic         neg;
    } res_t;

    int   checks = 0;
    int   errors = 0;
    logic m_v [0:N];
    res_t m_r [0:N];
    logic ready_en;

    // Plain arithmetic reference: sum/difference, unsigned carry/not-borrow, signed range overflow.
    function automatic res_t ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic cin, input logic sub);
        res_t        r;
        logic [W:0]  full;
        longint      sr;
        if (!sub) begin
            full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            r.cout = full[W];
            sr     = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
        end else begin
            full   = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin};
            r.cout = ~full[W];
            sr     = longint'($signed(a)) - longint'($signed(b)) - longint'(cin);
        end
        r.s    = full[W-1:0];
        r.ovf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        r.zero = (r.s == {W{1'b0}});
        r.neg  = r.s[W-1];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check in_ready, advance the ideal pipe, check outputs after the edge.
    task automatic tick(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, input logic rdy, output logic acc);
        logic stall;
        logic exp_rdy;
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_cin    = cin;
        in_sub    = sub;
        out_ready = rdy;
        #1;
        stall   = m_v[N] & ~rdy;
        exp_rdy = ready_en & ~stall;
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        acc = v & exp_rdy;
        @(posedge clk);
        ready_en = 1'b1;
        if (!stall) begin
            for (int i = N; i > 0; i--) begin
                m_v[i] = m_v[i-1];
                m_r[i] = m_r[i-1];
            end
            m_v[0] = acc;
            if (acc) m_r[0] = ref_model(a, b, cin, sub);
        end
        #1;
        chk("out_valid", 64'(out_valid), 64'(m_v[N]));
        if (m_v[N]) begin
            chk("out_s",    64'(out_s),    64'(m_r[N].s));
            chk("out_cout", 64'(out_cout), 64'(m_r[N].cout));
            chk("out_ovf",  64'(out_ovf),  64'(m_r[N].ovf));
            chk("out_zero", 64'(out_zero), 64'(m_r[N].zero));
            chk("out_neg",  64'(out_neg),  64'(m_r[N].neg));
        end
    endtask

    task automatic idle(input logic rdy);
        logic acc;
        tick(1'b0, {W{1'b0}}, {W{1'b0}}, 1'b0, 1'b0, rdy, acc);
    endtask

    // Single beat with hand-computed expectations, visible two edges after accept.
    task automatic single(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub, input logic [W-1:0] s,
                          input logic cout, input logic ovf, input logic zero, input logic neg);
        logic acc;
        tick(1'b1, a, b, cin, sub, 1'b1, acc);
        idle(1'b1);
        idle(1'b1);
        chk({tag, ".valid"}, 64'(out_valid), 64'd1);
        chk({tag, ".s"},     64'(out_s),     64'(s));
        chk({tag, ".cout"},  64'(out_cout),  64'(cout));
        chk({tag, ".ovf"},   64'(out_ovf),   64'(ovf));
        chk({tag, ".zero"},  64'(out_zero),  64'(zero));
        chk({tag, ".neg"},   64'(out_neg),   64'(neg));
        idle(1'b1);
    endtask

    logic [W-1:0] bp_a [0:3];
    logic [W-1:0] bp_b [0:3];
    logic         bp_c [0:3];
    logic         bp_u [0:3];

    initial begin
        logic acc;
        int   idx;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = {W{1'b0}};
        in_b      = {W{1'b0}};
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b1;
        ready_en  = 1'b0;
        for (int i = 0; i <= N; i++) begin
            m_v[i] = 1'b0;
            m_r[i] = '0;
        end

        #12;
        chk("rst.valid", 64'(out_valid), 64'd0);
        chk("rst.s",     64'(out_s),     64'd0);
        chk("rst.flags", 64'({out_cout, out_ovf, out_zero, out_neg}), 64'd0);
        chk("rst.ready", 64'(in_ready),  64'd0);
        rst = 1'b0;
        idle(1'b1);

        single("carry_chain", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
        single("ovf_add",     32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
        single("ovf_sub",     32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);
        single("sub_borrow1", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0, 1'b1);
        single("sub_borrow0", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1);

        // Back-to-back streaming, downstream always ready.
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'b1, acc);
        end
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Four beats with downstream stalled for three cycles mid-stream.
        for (int i = 0; i < 4; i++) begin
            bp_a[i] = W'($urandom);
            bp_b[i] = W'($urandom);
            bp_c[i] = 1'($urandom_range(0, 1));
            bp_u[i] = 1'($urandom_range(0, 1));
        end
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            if (idx < 4) begin
                tick(1'b1, bp_a[idx], bp_b[idx], bp_c[idx], bp_u[idx], !(c >= 3 && c < 6), acc);
                if (acc) idx++;
            end else begin
                idle(!(c >= 3 && c < 6));
            end
        end

        // Random valid and backpressure mix.
        for (int i = 0; i < 80; i++) begin
            tick(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), acc);
        end
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Asynchronous reset pulse between edges with two beats in flight.
        tick(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b1, acc);
        tick(1'b1, 32'hDEAD_BEEF, 32'h0000_0001, 1'b1, 1'b1, 1'b1, acc);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst.valid", 64'(out_valid), 64'd0);
        chk("midrst.s",     64'(out_s),     64'd0);
        chk("midrst.flags", 64'({out_cout, out_ovf, out_zero, out_neg}), 64'd0);
        for (int i = 0; i <= N; i++) m_v[i] = 1'b0;
        ready_en = 1'b0;
        #1;
        rst = 1'b0;
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        single("post_rst", 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 32'h0000_0030, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
